// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ writeback sources.
// Optional WB_BYPASS_EN adds a combinational read bypass from the output stage.
module rf_wb_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    stall_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    rf_we_o,
  output logic [ADDR_W-1:0]       rf_addr_o,
  output logic [DATA_W-1:0]       rf_data_o,
  output logic [2:0]              grant_id_o,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0]       rs1_addr_i,
  input  logic [ADDR_W-1:0]       rs2_addr_i,
  input  logic [DATA_W-1:0]       rf_rs1_data_i,
  input  logic [DATA_W-1:0]       rf_rs2_data_i,
  output logic [DATA_W-1:0]       rs1_data_o,
  output logic [DATA_W-1:0]       rs2_data_o,
`endif
  output logic                    busy_o
);

  logic              stage_valid_q, stage_valid_d;
  logic [ADDR_W-1:0] stage_addr_q, stage_addr_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;
  logic [2:0]        stage_id_q, stage_id_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;

  logic [7:0]        valid_pad;
  logic [3:0]        idx;
  logic              gnt_any;
  logic [2:0]        gnt_idx;
  logic [2:0]        ptr_next;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Padding to 8 lets a 3-bit index address the valid vector for any N_REQ.
  assign valid_pad = 8'(req_valid_i);

  // Search upward from rr_ptr, wrapping modulo N_REQ; first valid wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    if (!stall_i) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        idx = {1'b0, rr_ptr_q} + 4'(i);
        if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
        if (!gnt_any && valid_pad[idx[2:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = idx[2:0];
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    gnt_addr    = '0;
    gnt_data    = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (gnt_any && (gnt_idx == 3'(j))) begin
        req_ready_o[j] = 1'b1;
        gnt_addr       = req_addr_i[j*ADDR_W +: ADDR_W];
        gnt_data       = req_data_i[j*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = (({1'b0, gnt_idx} + 4'd1) == 4'(N_REQ)) ? 3'd0 : gnt_idx + 3'd1;

  always_comb begin
    stage_valid_d = gnt_any;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    stage_id_d    = stage_id_q;
    rr_ptr_d      = rr_ptr_q;
    if (gnt_any) begin
      stage_addr_d = gnt_addr;
      stage_data_d = gnt_data;
      stage_id_d   = gnt_idx;
      rr_ptr_d     = ptr_next;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
      stage_id_q    <= '0;
      rr_ptr_q      <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
      stage_id_q    <= stage_id_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  // Writes to x0 complete the handshake but never reach the register file.
  assign rf_we_o    = stage_valid_q && (stage_addr_q != '0);
  assign rf_addr_o  = stage_addr_q;
  assign rf_data_o  = stage_data_q;
  assign grant_id_o = stage_id_q;
  assign busy_o     = (|req_valid_i) || stage_valid_q;

`ifdef WB_BYPASS_EN
  // Covers the half-cycle before the register file's negedge write lands.
  assign rs1_data_o = (stage_valid_q && (stage_addr_q == rs1_addr_i) && (rs1_addr_i != '0))
                      ? stage_data_q : rf_rs1_data_i;
  assign rs2_data_o = (stage_valid_q && (stage_addr_q == rs2_addr_i) && (rs2_addr_i != '0))
                      ? stage_data_q : rf_rs2_data_i;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: grants modelled at drive time, stage outputs checked a
// cycle later. Bypass checks compile in only with WB_BYPASS_EN.
module tb_rf_wb_arbiter;

  localparam int unsigned N = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          has;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    id;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            stall = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_addr;
  logic [DW-1:0]   rf_data;
  logic [2:0]      grant_id;
  logic            busy;
`ifdef WB_BYPASS_EN
  logic [AW-1:0]   rs1_addr = '0, rs2_addr = '0;
  logic [DW-1:0]   rf_rs1_data = '0, rf_rs2_data = '0;
  logic [DW-1:0]   rs1_data, rs2_data;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .stall_i       (stall),
    .req_valid_i   (req_valid),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .rf_we_o       (rf_we),
    .rf_addr_o     (rf_addr),
    .rf_data_o     (rf_data),
    .grant_id_o    (grant_id),
`ifdef WB_BYPASS_EN
    .rs1_addr_i    (rs1_addr),
    .rs2_addr_i    (rs2_addr),
    .rf_rs1_data_i (rf_rs1_data),
    .rf_rs2_data_i (rf_rs2_data),
    .rs1_data_o    (rs1_data),
    .rs2_data_o    (rs2_data),
`endif
    .busy_o        (busy)
  );

  int            n_total = 0;
  int            n_bad = 0;
  int            mptr = 0;
  logic          cur_has = 1'b0;
  exp_t          sbq[$];
  logic [AW-1:0] addr_m[N];
  logic [DW-1:0] data_m[N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1: compare the stage against the oldest expectation.
  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      cur_has = 1'b0;
    end else begin
      e = sbq.pop_front();
      cur_has = e.has;
      if (e.has) begin
        check_eq("rf_we", 64'(rf_we), 64'(e.addr != '0));
        check_eq("rf_addr", 64'(rf_addr), 64'(e.addr));
        check_eq("rf_data", 64'(rf_data), 64'(e.data));
        check_eq("grant_id", 64'(grant_id), 64'(e.id));
      end else begin
        check_eq("rf_we_idle", 64'(rf_we), 64'd0);
      end
    end
  endtask

  task automatic drive_and_push(input logic [N-1:0] v, input logic st);
    exp_t         e;
    logic [N-1:0] exp_rdy;
    logic         found;
    int           ix;
    req_valid = v;
    stall = st;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr_m[i];
      req_data[i*DW +: DW] = data_m[i];
    end
    #1;
    e = '0;
    exp_rdy = '0;
    found = 1'b0;
    if (!st) begin
      for (int k = 0; k < N; k++) begin
        ix = (mptr + k) % N;
        if (!found && v[ix]) begin
          found = 1'b1;
          exp_rdy[ix] = 1'b1;
          e = '{1'b1, addr_m[ix], data_m[ix], 3'(ix)};
        end
      end
    end
    check_eq("ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("busy", 64'(busy), 64'((|v) | cur_has));
    if (found) mptr = (int'(e.id) + 1) % N;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] v, input logic st);
    @(posedge clk);
    #1;
    pop_check();
    drive_and_push(v, st);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      addr_m[i] = AW'(i + 1);
      data_m[i] = 32'hC0DE_0000 + DW'(i);
    end
    req_valid = 3'b111;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("rst_we", 64'(rf_we), 64'd0);
      check_eq("rst_addr", 64'(rf_addr), 64'd0);
      check_eq("rst_data", 64'(rf_data), 64'd0);
      check_eq("rst_id", 64'(grant_id), 64'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    drive_and_push(3'b111, 1'b0);

    // Round robin: 0,1,2,0,1,2 with all three valid.
    repeat (5) step(3'b111, 1'b0);

    // Single write from requester 0.
    addr_m[0] = 5'd5;
    data_m[0] = 32'hDEADBEEF;
    step(3'b001, 1'b0);
    step(3'b000, 1'b0);

    // Write to x0 from requester 1.
    addr_m[1] = 5'd0;
    data_m[1] = 32'h12345678;
    step(3'b010, 1'b0);
    step(3'b000, 1'b0);

    // Stall mid-stream after a requester-2 grant; pointer resumes at 0.
    addr_m[2] = 5'd9;
    data_m[2] = 32'h0BAD_F00D;
    step(3'b100, 1'b0);
    repeat (3) step(3'b100, 1'b1);
    addr_m[1] = 5'd4;
    step(3'b111, 1'b0);
    step(3'b000, 1'b0);

    // Stage holds addr 7 from requester 0 for the bypass checks.
    addr_m[0] = 5'd7;
    data_m[0] = 32'hA5A5A5A5;
    step(3'b001, 1'b0);
    @(posedge clk);
    #1;
    pop_check();
`ifdef WB_BYPASS_EN
    rs1_addr = 5'd7;
    rf_rs1_data = '0;
    rs2_addr = 5'd3;
    rf_rs2_data = 32'h0000_3333;
    #1;
    check_eq("byp_rs1_hit", 64'(rs1_data), 64'h A5A5A5A5);
    check_eq("byp_rs2_miss", 64'(rs2_data), 64'h0000_3333);
    rs1_addr = 5'd0;
    rf_rs1_data = 32'h0000_0011;
    #1;
    check_eq("byp_rs1_x0", 64'(rs1_data), 64'h0000_0011);
`endif
    drive_and_push(3'b000, 1'b0);
    step(3'b000, 1'b0);

    // Reset while a write sits in the stage: it must vanish.
    step(3'b001, 1'b0);
    @(posedge clk);
    #1;
    pop_check();
    rstn = 1'b0;
    #1;
    check_eq("midrst_we", 64'(rf_we), 64'd0);
    check_eq("midrst_addr", 64'(rf_addr), 64'd0);
    check_eq("midrst_id", 64'(grant_id), 64'd0);
    sbq.delete();
    mptr = 0;
    cur_has = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    step(3'b111, 1'b0);
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    @(posedge clk);
    #1;
    pop_check();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port among N_REQ writeback requesters, e.g. ALU result, load return and CSR read-back.
- Accepts one write per cycle using a valid/ready handshake and round-robin priority.
- Registers the winning write into a one-entry output stage that drives the register file's write port.
- The output stage is driven from the posedge and held a full cycle, so the register file's negedge write samples stable values.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register address width

Ports:
clk_i  input  1  clock; all state updates on posedge
rstn_i  input  1  asynchronous active-low reset
stall_i  input  1  when 1, no grants are issued; the output stage drains
req_valid_i  input  N_REQ  per-requester write request
req_addr_i  input  N_REQ*ADDR_W  packed destination addresses, requester 0 in the LSBs
req_data_i  input  N_REQ*DATA_W  packed write data, requester 0 in the LSBs
req_ready_o  output  N_REQ  one-hot grant; a write is accepted when valid&ready in the same cycle
rf_we_o  output  1  register-file write enable
rf_addr_o  output  ADDR_W  register-file write address
rf_data_o  output  DATA_W  register-file write data
grant_id_o  output  3  index of the requester whose write is in the output stage
busy_o  output  1  1 when any req_valid_i is high or the output stage is valid

Behaviour:
- Reset (asynchronous, rstn_i=0):
  - stage_valid=0, rf_we_o=0, rf_addr_o=0, rf_data_o=0, grant_id_o=0.
  - Round-robin pointer rr_ptr=0.
  - Reset applied mid-operation discards any staged write; that write is never performed.
- Grant (combinational):
  - If stall_i=0 and any req_valid_i is set, exactly one req_ready_o bit is high.
  - The granted requester is the first valid index found searching upward from rr_ptr, wrapping modulo N_REQ.
  - req_ready_o is never high for a requester whose req_valid_i is 0.
  - All req_ready_o bits are 0 when stall_i=1 or no request is valid.
- Stage load (posedge):
  - On a grant: stage_valid=1, the stage captures the granted address, data and index, and rr_ptr becomes (granted index + 1) mod N_REQ.
  - With no grant: stage_valid=0 and rr_ptr holds.
  - The register file always accepts, so the stage drains every cycle; there is no backpressure from the write port.
- Outputs: rf_we_o = stage_valid & (stage_addr != 0).
  - A write to x0 is accepted (handshake completes) but never asserts rf_we_o.
  - rf_addr_o and rf_data_o reflect the stage registers unconditionally.
- Latency: accept in cycle N, rf_we_o high in cycle N+1, register file updated at the negedge of cycle N+1.
- Throughput: one write per cycle, sustained.
- Fairness: with all N_REQ continuously valid, grants rotate 0,1,..,N_REQ-1,0; the maximum wait is N_REQ-1 cycles.
- Same-address writes from different requesters are not merged. They retire in grant order, and the last one granted wins.
- A requester must hold valid, addr and data stable until accepted; the arbiter does not register unaccepted requests.
- stall_i asserted mid-stream: the current stage still writes in the next cycle, then rf_we_o=0. rr_ptr is preserved across the stall.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined, these ports are added:
  - rs1_addr_i, rs2_addr_i (ADDR_W) inputs
  - rf_rs1_data_i, rf_rs2_data_i (DATA_W) inputs
  - rs1_data_o, rs2_data_o (DATA_W) outputs
- rsX_data_o = stage data when stage_valid=1 and stage_addr==rsX_addr_i and rsX_addr_i!=0; otherwise rsX_data_o = rf_rsX_data_i.
- The bypass is purely combinational. It covers the first half-cycle, before the register file's negedge write lands.
- When the macro is not defined, these ports and their logic are absent.

Test Plan:
- Reset: hold rstn_i=0, drive req_valid_i=3'b111 -> rf_we_o=0 and rf_addr_o=0 throughout; deassert reset -> first grant goes to requester 0.
- Single write: req0 valid, addr=5, data=32'hDEADBEEF for one cycle -> req_ready_o=3'b001 that cycle; next cycle rf_we_o=1, rf_addr_o=5, rf_data_o=32'hDEADBEEF, grant_id_o=0.
- Round-robin: all three valid for 6 cycles with distinct addrs 1,2,3 -> grant order 0,1,2,0,1,2; each requester waits at most 2 cycles.
- x0 write: req1 addr=0, data=32'h12345678 -> req_ready_o[1]=1; next cycle rf_we_o=0.
- Stall mid-stream: req2 accepted in cycle N, stall_i=1 during cycles N+1..N+3 -> rf_we_o=1 in N+1 only, req_ready_o=0 during the stall, rr_ptr resumes at 0 afterwards.
- Bypass (WB_BYPASS_EN): stage holds addr=7, data=32'hA5A5A5A5, rs1_addr_i=7, rf_rs1_data_i=0 -> rs1_data_o=32'hA5A5A5A5; with rs1_addr_i=0 -> rs1_data_o=rf_rs1_data_i.
